// File: rtl/pattern_count_pkg.sv
// Shared types and sizing for the pattern detector / occurrence counter.
// No logic; constants and the control FSM state encoding only.
// Imported by the matcher, the engine top and the bench.
package pattern_count_pkg;

  localparam int PC_PATTERN_WIDTH = 3;
  localparam int PC_COUNT_WIDTH   = 10;
  localparam logic [PC_COUNT_WIDTH-1:0] PC_COUNT_MAX = '1;

  typedef enum logic [1:0] {
    PC_IDLE  = 2'd0,
    PC_ARMED = 2'd1,
    PC_RUN   = 2'd2,
    PC_DONE  = 2'd3
  } pc_state_t;

endpackage

// File: rtl/pattern_shift_matcher.sv
// Serial history shift register with fill counter and a combinational window compare.
// Match is same-cycle combinational on sig_in; history/fill update one edge after shift_en.
// No backpressure: every shift_en pulse is consumed.
module pattern_shift_matcher
  import pattern_count_pkg::*;
#(
  parameter int WIDTH = PC_PATTERN_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             shift_en,
  input  logic             sig_in,
  input  logic [WIDTH-1:0] pattern,
  output logic             fill_full,
  output logic             match
);

  localparam int FW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(WIDTH - 1);

  // Only the newest WIDTH-1 bits are ever needed; the live sample completes the window.
  logic [WIDTH-2:0] history;
  logic [FW-1:0]    fill;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      history <= '0;
      fill    <= '0;
    end else if (shift_en) begin
      history <= {history[WIDTH-3:0], sig_in};
      if (fill != FILL_MAX) fill <= fill + FW'(1);
    end
  end

  assign fill_full = (fill == FILL_MAX);
  assign match     = fill_full && ({history, sig_in} == pattern);

endmodule

// File: rtl/pattern_count_engine.sv
// Counts overlapping occurrences of a 3-bit pattern in a strobed serial stream up to a target.
// Count, done and interrupt update one edge after the accepted sample.
// No backpressure: samples are taken whenever SignalEnable is high in ARMED/RUN.
module pattern_count_engine
  import pattern_count_pkg::*;
#(
  parameter int PATTERN_WIDTH = PC_PATTERN_WIDTH,
  parameter int COUNT_WIDTH   = PC_COUNT_WIDTH
) (
  input  logic                     s00_axi_aclk,
  input  logic                     s00_axi_areset,
  input  logic                     Start,
  input  logic                     Clear,
  input  logic                     SignalEnable,
  input  logic                     SignalIn,
  input  logic [PATTERN_WIDTH-1:0] PatternIn,
  input  logic [COUNT_WIDTH-1:0]   CountTarget,
  output logic [COUNT_WIDTH-1:0]   PatternCountTotal,
  output logic                     PatternCountDone,
  output logic                     PatternCountDone_interrupt,
  output logic                     Busy
);

  pc_state_t state;
  logic      active;
  logic      accept;
  logic      flush;
  logic      fill_full;
  logic      match;
  logic      reach;
  logic [COUNT_WIDTH:0] count_inc;

  assign active = (state == PC_ARMED) || (state == PC_RUN);
  // A sample that coincides with a control pulse is discarded.
  assign accept = SignalEnable && active && !Start && !Clear;
  assign flush  = Clear || Start || (state == PC_IDLE);

  assign count_inc = {1'b0, PatternCountTotal} + (COUNT_WIDTH + 1)'(1);
  assign reach     = (CountTarget != '0) && (count_inc == {1'b0, CountTarget});

  pattern_shift_matcher #(.WIDTH(PATTERN_WIDTH)) u_matcher (
    .clk       (s00_axi_aclk),
    .rst       (s00_axi_areset),
    .flush     (flush),
    .shift_en  (accept),
    .sig_in    (SignalIn),
    .pattern   (PatternIn),
    .fill_full (fill_full),
    .match     (match)
  );

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      state                      <= PC_IDLE;
      PatternCountTotal          <= '0;
      PatternCountDone           <= 1'b0;
      PatternCountDone_interrupt <= 1'b0;
      Busy                       <= 1'b0;
    end else begin
      PatternCountDone_interrupt <= 1'b0;
      if (Clear) begin
        state             <= PC_IDLE;
        PatternCountTotal <= '0;
        PatternCountDone  <= 1'b0;
        Busy              <= 1'b0;
      end else if (Start) begin
        state             <= PC_ARMED;
        PatternCountTotal <= '0;
        PatternCountDone  <= 1'b0;
        Busy              <= 1'b1;
      end else if (accept) begin
        if (fill_full) state <= PC_RUN;
        if (match) begin
          if (PatternCountTotal != '1) PatternCountTotal <= count_inc[COUNT_WIDTH-1:0];
          if (reach) begin
            state                      <= PC_DONE;
            PatternCountDone           <= 1'b1;
            PatternCountDone_interrupt <= 1'b1;
            Busy                       <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_count_engine.sv
// Scoreboard bench: a queue-history reference model pushes expected outputs per driven cycle.
module tb_pattern_count_engine;
  import pattern_count_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, clr, en, sig;
  logic [2:0] pat;
  logic [9:0] tgt;
  logic [9:0] cnt_o;
  logic       done_o, irq_o, busy_o;

  pattern_count_engine dut (
    .s00_axi_aclk               (clk),
    .s00_axi_areset             (rst),
    .Start                      (start),
    .Clear                      (clr),
    .SignalEnable               (en),
    .SignalIn                   (sig),
    .PatternIn                  (pat),
    .CountTarget                (tgt),
    .PatternCountTotal          (cnt_o),
    .PatternCountDone           (done_o),
    .PatternCountDone_interrupt (irq_o),
    .Busy                       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int done;
    int irq;
    int busy;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   irq_seen = 0;

  // Reference model: 0 idle, 1 armed/run, 2 done
  int   m_state = 0;
  int   m_cnt   = 0;
  int   m_done  = 0;
  bit   m_hist[$];

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic c, input logic e, input logic b);
    exp_t x;
    rst = r; start = s; clr = c; en = e; sig = b;
    x.irq = 0;
    if (r || c) begin
      m_state = 0; m_cnt = 0; m_done = 0; m_hist.delete();
    end else if (s) begin
      m_state = 1; m_cnt = 0; m_done = 0; m_hist.delete();
    end else if (e && m_state == 1) begin
      m_hist.push_back(b);
      if (m_hist.size() > 3) void'(m_hist.pop_front());
      if (m_hist.size() == 3 && {m_hist[0], m_hist[1], m_hist[2]} == pat) begin
        if (tgt != 0 && m_cnt + 1 == int'(tgt)) begin
          m_state = 2; m_done = 1; x.irq = 1;
        end
        if (m_cnt < 1023) m_cnt++;
      end
    end
    x.cnt = m_cnt; x.done = m_done; x.busy = (m_state == 1) ? 1 : 0;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("cnt", int'(cnt_o), x.cnt);
    chk("done", int'(done_o), x.done);
    chk("irq", int'(irq_o), x.irq);
    chk("busy", int'(busy_o), x.busy);
    irq_seen += int'(irq_o);
  endtask

  task automatic samp(input logic b);
    step(1'b0, 1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic arm();
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clr = 1'b0; en = 1'b0; sig = 1'b0;
    pat = 3'b000; tgt = 10'd0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_cnt", int'(cnt_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_busy", int'(busy_o), 0);

    // Overlapping matches, no target
    pat = 3'b101; tgt = 10'd0;
    arm();
    samp(1); samp(0); samp(1); samp(0); samp(1);
    chk("t1_cnt", int'(cnt_o), 2);
    chk("t1_done", int'(done_o), 0);
    chk("t1_busy", int'(busy_o), 1);

    // Target reached, single pulse, count frozen afterwards
    pat = 3'b111; tgt = 10'd3; irq_seen = 0;
    arm();
    for (int i = 0; i < 5; i++) samp(1);
    chk("t2_cnt", int'(cnt_o), 3);
    chk("t2_done", int'(done_o), 1);
    chk("t2_irq_now", int'(irq_o), 1);
    samp(1); samp(1); samp(1);
    chk("t2_cnt_hold", int'(cnt_o), 3);
    chk("t2_irq_total", irq_seen, 1);

    // Saturation
    pat = 3'b000; tgt = 10'd0; irq_seen = 0;
    arm();
    for (int i = 0; i < 1100; i++) samp(0);
    chk("t3_cnt_sat", int'(cnt_o), 1023);
    chk("t3_done", int'(done_o), 0);
    chk("t3_irq_total", irq_seen, 0);

    // Start and Clear together: Clear wins
    pat = 3'b101;
    arm();
    samp(1); samp(0); samp(1); samp(0); samp(1);
    chk("t4_cnt_pre", int'(cnt_o), 2);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t4_cnt_clr", int'(cnt_o), 0);
    chk("t4_busy_clr", int'(busy_o), 0);
    samp(1); samp(0); samp(1); samp(0); samp(1);
    chk("t4_cnt_ignored", int'(cnt_o), 0);

    // Fill then first compare, with disabled cycles interleaved
    pat = 3'b110;
    arm();
    samp(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    samp(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    samp(0);
    chk("t5_cnt", int'(cnt_o), 1);
    samp(0);
    chk("t5_cnt_after", int'(cnt_o), 1);

    // Reset in RUN aborts without an interrupt
    pat = 3'b101; irq_seen = 0;
    arm();
    for (int i = 0; i < 11; i++) samp(((i % 2) == 0) ? 1'b1 : 1'b0);
    chk("t6_cnt_pre", int'(cnt_o), 5);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_cnt_rst", int'(cnt_o), 0);
    chk("t6_busy_rst", int'(busy_o), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_irq_total", irq_seen, 0);

    // Re-run reaching the target again gives a fresh pulse
    pat = 3'b111; tgt = 10'd2; irq_seen = 0;
    arm();
    for (int i = 0; i < 4; i++) samp(1);
    arm();
    for (int i = 0; i < 4; i++) samp(1);
    chk("t7_irq_total", irq_seen, 2);
    chk("t7_cnt", int'(cnt_o), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
